// File: rtl/memif_arb2_pkg.sv
// Shared definitions for the two-client mi_* bus arbiter.
// Direction codes, FSM state encoding and the end-of-burst test.
package memif_arb2_pkg;

    localparam logic MI_RW_WRITE = 1'b0;
    localparam logic MI_RW_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CMD  = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    // Only the strobe pair matching the latched direction closes a burst.
    function automatic logic burst_end(
        input logic dir,
        input logic wack,
        input logic wlast,
        input logic rstb,
        input logic rlast
    );
        if (dir == MI_RW_WRITE)
            return wack & wlast;
        else
            return rstb & rlast;
    endfunction

endpackage

// File: rtl/memif_arb2_rr.sv
// Two-way round-robin picker, purely combinational.
// On a tie the client that did not win last time is chosen.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);

    // Tie goes to ~last, a single request wins outright.
    always_comb begin
        any = |req;
        gnt = 1'b0;
        if (req == 2'b11)
            gnt = ~last;
        else
            gnt = req[1];
    end

endmodule

// File: rtl/memif_arb2.sv
// Two-client arbiter for the mi_* command/burst bus.
// One burst outstanding; the grant holds from command to last beat.
module memif_arb2 #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [LEN_W-1:0]  c0_len,
    input  logic              c0_rw,
    input  logic              c0_valid,
    output logic              c0_ready,
    input  logic [15:0]       c0_wdata,
    output logic              c0_wack,
    output logic              c0_wlast,
    output logic [15:0]       c0_rdata,
    output logic              c0_rstb,
    output logic              c0_rlast,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [LEN_W-1:0]  c1_len,
    input  logic              c1_rw,
    input  logic              c1_valid,
    output logic              c1_ready,
    input  logic [15:0]       c1_wdata,
    output logic              c1_wack,
    output logic              c1_wlast,
    output logic [15:0]       c1_rdata,
    output logic              c1_rstb,
    output logic              c1_rlast,
    output logic [ADDR_W-1:0] mi_addr,
    output logic [LEN_W-1:0]  mi_len,
    output logic              mi_rw,
    output logic              mi_valid,
    input  logic              mi_ready,
    output logic [15:0]       mi_wdata,
    input  logic              mi_wack,
    input  logic              mi_wlast,
    input  logic [15:0]       mi_rdata,
    input  logic              mi_rstb,
    input  logic              mi_rlast
);

    import memif_arb2_pkg::*;

    state_t r_state;
    logic   r_gnt;
    logic   r_last_gnt;
    logic   r_dir;

    state_t w_state_nxt;
    logic   w_gnt_nxt;
    logic   w_last_nxt;
    logic   w_dir_nxt;

    logic   w_pick;
    logic   w_any;
    logic   w_gvalid;
    logic   w_grw;
    logic   w_acc;
    logic   w_data;
    logic   w_end;

    arb_rr2 u_rr (
        .req  ({c1_valid, c0_valid}),
        .last (r_last_gnt),
        .gnt  (w_pick),
        .any  (w_any)
    );

    // Command and write-data mux follow the current grant.
    always_comb begin
        mi_addr  = r_gnt ? c1_addr  : c0_addr;
        mi_len   = r_gnt ? c1_len   : c0_len;
        w_grw    = r_gnt ? c1_rw    : c0_rw;
        mi_wdata = r_gnt ? c1_wdata : c0_wdata;
        w_gvalid = r_gnt ? c1_valid : c0_valid;
        mi_rw    = w_grw;
        mi_valid = (r_state == ST_CMD) & w_gvalid;
        w_acc    = mi_valid & mi_ready;
        c0_ready = w_acc & ~r_gnt;
        c1_ready = w_acc &  r_gnt;
    end

    // Completion strobes go to the granted client only, during data phase.
    always_comb begin
        w_data   = (r_state == ST_DATA);
        c0_wack  = w_data & ~r_gnt & mi_wack;
        c0_wlast = w_data & ~r_gnt & mi_wlast;
        c0_rstb  = w_data & ~r_gnt & mi_rstb;
        c0_rlast = w_data & ~r_gnt & mi_rlast;
        c1_wack  = w_data &  r_gnt & mi_wack;
        c1_wlast = w_data &  r_gnt & mi_wlast;
        c1_rstb  = w_data &  r_gnt & mi_rstb;
        c1_rlast = w_data &  r_gnt & mi_rlast;
        c0_rdata = mi_rdata;
        c1_rdata = mi_rdata;
        w_end    = w_data & burst_end(r_dir, mi_wack, mi_wlast,
                                      mi_rstb, mi_rlast);
    end

    // Next-state logic for the IDLE/CMD/DATA sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last_gnt;
        w_dir_nxt   = r_dir;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_acc) begin
                    w_dir_nxt   = w_grw;
                    w_last_nxt  = r_gnt;
                    w_state_nxt = ST_DATA;
                end else if (!w_gvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_end)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_dir      <= MI_RW_WRITE;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_last_gnt <= w_last_nxt;
            r_dir      <= w_dir_nxt;
        end
    end

endmodule

// File: tb/tb_memif_arb2.sv
// Directed testbench for memif_arb2.
// Inputs change just after negedge; outputs checked 1 ns later.
module tb_memif_arb2;

    logic        clk;
    logic        rst;
    logic [31:0] c0_addr, c1_addr, mi_addr;
    logic [6:0]  c0_len, c1_len, mi_len;
    logic        c0_rw, c1_rw, mi_rw;
    logic        c0_valid, c1_valid, mi_valid;
    logic        c0_ready, c1_ready, mi_ready;
    logic [15:0] c0_wdata, c1_wdata, mi_wdata;
    logic        c0_wack, c1_wack, mi_wack;
    logic        c0_wlast, c1_wlast, mi_wlast;
    logic [15:0] c0_rdata, c1_rdata, mi_rdata;
    logic        c0_rstb, c1_rstb, mi_rstb;
    logic        c0_rlast, c1_rlast, mi_rlast;

    int n_pass = 0;
    int n_tot  = 0;

    memif_arb2 dut (
        .clk(clk), .rst(rst),
        .c0_addr(c0_addr), .c0_len(c0_len), .c0_rw(c0_rw),
        .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_wdata(c0_wdata),
        .c0_wack(c0_wack), .c0_wlast(c0_wlast), .c0_rdata(c0_rdata),
        .c0_rstb(c0_rstb), .c0_rlast(c0_rlast),
        .c1_addr(c1_addr), .c1_len(c1_len), .c1_rw(c1_rw),
        .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_wdata(c1_wdata),
        .c1_wack(c1_wack), .c1_wlast(c1_wlast), .c1_rdata(c1_rdata),
        .c1_rstb(c1_rstb), .c1_rlast(c1_rlast),
        .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
        .mi_valid(mi_valid), .mi_ready(mi_ready), .mi_wdata(mi_wdata),
        .mi_wack(mi_wack), .mi_wlast(mi_wlast), .mi_rdata(mi_rdata),
        .mi_rstb(mi_rstb), .mi_rlast(mi_rlast)
    );

    always #5 clk = ~clk;

    task automatic clr_ctl();
        mi_ready = 0; mi_wack = 0; mi_wlast = 0;
        mi_rstb = 0; mi_rlast = 0; mi_rdata = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; c0_valid = 1; c1_valid = 1;
        mi_ready = 1; mi_wack = 1; mi_wlast = 1;
        mi_rstb = 1; mi_rlast = 1;
        c0_addr = 32'h55; c0_wdata = 16'h1234;
        @(negedge clk); #1;
        n_tot++;
        if (mi_valid !== 1'b0)
            $display("FAIL rst_mi_valid got %b want 0", mi_valid);
        else n_pass++;
        n_tot++;
        if ({c1_ready, c0_ready} !== 2'b00)
            $display("FAIL rst_ready got %b want 00", {c1_ready, c0_ready});
        else n_pass++;
        n_tot++;
        if ({c0_wack, c0_wlast, c0_rstb, c0_rlast,
             c1_wack, c1_wlast, c1_rstb, c1_rlast} !== 8'h00)
            $display("FAIL rst_strobes got %b want 0",
                     {c0_wack, c0_wlast, c0_rstb, c0_rlast,
                      c1_wack, c1_wlast, c1_rstb, c1_rlast});
        else n_pass++;
        n_tot++;
        if (mi_addr !== 32'h55 || mi_wdata !== 16'h1234)
            $display("FAIL rst_mux_c0 got %h/%h want 55/1234",
                     mi_addr, mi_wdata);
        else n_pass++;
        c0_valid = 0; c1_valid = 0; clr_ctl();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_write_burst();
        @(negedge clk);
        c0_addr = 32'h100; c0_len = 7'd63; c0_rw = 0; c0_valid = 1;
        #1;
        n_tot++;
        if (mi_valid !== 1'b0)
            $display("FAIL wr_idle_valid got %b want 0", mi_valid);
        else n_pass++;
        @(negedge clk); #1;
        n_tot++;
        if ({mi_valid, mi_addr, mi_rw, mi_len, c0_ready} !==
            {1'b1, 32'h100, 1'b0, 7'd63, 1'b0})
            $display("FAIL wr_cmd got v=%b a=%h rw=%b l=%0d r=%b want 1 100 0 63 0",
                     mi_valid, mi_addr, mi_rw, mi_len, c0_ready);
        else n_pass++;
        mi_ready = 1; #1;
        n_tot++;
        if ({c1_ready, c0_ready} !== 2'b01)
            $display("FAIL wr_ready got %b want 01", {c1_ready, c0_ready});
        else n_pass++;
        @(negedge clk);
        c0_valid = 0; mi_ready = 0;
        for (int i = 0; i < 64; i++) begin
            c0_wdata = 16'hC000 + 16'(i);
            mi_wack = 1; mi_wlast = (i == 63);
            #1;
            n_tot++;
            if ({c0_wack, c1_wack, c0_wlast, mi_valid, mi_wdata} !==
                {1'b1, 1'b0, (i == 63), 1'b0, 16'hC000 + 16'(i)})
                $display("FAIL wr_beat%0d got wa=%b/%b wl=%b v=%b d=%h",
                         i, c0_wack, c1_wack, c0_wlast, mi_valid, mi_wdata);
            else n_pass++;
            @(negedge clk);
        end
        mi_wack = 1; mi_wlast = 0; #1;
        n_tot++;
        if (c0_wack !== 1'b0)
            $display("FAIL wr_back_idle got c0_wack=%b want 0", c0_wack);
        else n_pass++;
        clr_ctl();
    endtask

    task automatic test_round_robin();
        logic exp;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        c0_addr = 32'h1000; c0_rw = 0; c0_len = 0; c0_valid = 1;
        c1_addr = 32'h2000; c1_rw = 0; c1_len = 0; c1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 1);
            @(negedge clk); mi_ready = 1; #1;
            n_tot++;
            if ({mi_valid, mi_addr, c1_ready, c0_ready} !==
                {1'b1, exp ? 32'h2000 : 32'h1000, exp, ~exp})
                $display("FAIL rr_grant%0d got v=%b a=%h r=%b%b want client %0d",
                         k, mi_valid, mi_addr, c1_ready, c0_ready, exp);
            else n_pass++;
            @(negedge clk);
            mi_ready = 0; mi_wack = 1; mi_wlast = 1; #1;
            n_tot++;
            if ({c1_wack, c0_wack} !== {exp, ~exp})
                $display("FAIL rr_wack%0d got %b%b want client %0d",
                         k, c1_wack, c0_wack, exp);
            else n_pass++;
            @(negedge clk);
            mi_wack = 0; mi_wlast = 0;
        end
        c0_valid = 0; c1_valid = 0;
    endtask

    task automatic test_read();
        c1_addr = 32'h3000; c1_len = 7'd3; c1_rw = 1; c1_valid = 1;
        @(negedge clk); mi_ready = 1; #1;
        n_tot++;
        if ({c1_ready, c0_ready, mi_rw, mi_len} !== {2'b10, 1'b1, 7'd3})
            $display("FAIL rd_cmd got r=%b%b rw=%b l=%0d want 10 1 3",
                     c1_ready, c0_ready, mi_rw, mi_len);
        else n_pass++;
        @(negedge clk);
        c1_valid = 0; mi_ready = 0;
        mi_wack = 1; mi_wlast = 1; #1;
        n_tot++;
        if ({c1_wack, c1_wlast, c0_wack} !== 3'b110)
            $display("FAIL rd_wrongdir got %b want 110",
                     {c1_wack, c1_wlast, c0_wack});
        else n_pass++;
        @(negedge clk);
        mi_wack = 0; mi_wlast = 0;
        for (int i = 0; i < 4; i++) begin
            mi_rstb = 1; mi_rdata = 16'hA5A0 + 16'(i); mi_rlast = (i == 3);
            #1;
            n_tot++;
            if ({c1_rstb, c0_rstb, c1_rlast, c0_rlast, c1_rdata} !==
                {1'b1, 1'b0, (i == 3), 1'b0, 16'hA5A0 + 16'(i)})
                $display("FAIL rd_beat%0d got s=%b%b l=%b%b d=%h",
                         i, c1_rstb, c0_rstb, c1_rlast, c0_rlast, c1_rdata);
            else n_pass++;
            @(negedge clk);
        end
        mi_rstb = 1; mi_rlast = 1; #1;
        n_tot++;
        if ({c1_rstb, c1_rlast, mi_valid} !== 3'b000)
            $display("FAIL rd_back_idle got %b want 000",
                     {c1_rstb, c1_rlast, mi_valid});
        else n_pass++;
        clr_ctl();
    endtask

    task automatic test_stall();
        c0_addr = 32'h200; c0_len = 7'd5; c0_rw = 0; c0_valid = 1;
        @(negedge clk);
        c1_addr = 32'h400; c1_len = 0; c1_rw = 0; c1_valid = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_tot++;
            if ({mi_valid, mi_addr, c0_ready, c1_ready} !==
                {1'b1, 32'h200, 2'b00})
                $display("FAIL stall%0d got v=%b a=%h r=%b%b",
                         i, mi_valid, mi_addr, c0_ready, c1_ready);
            else n_pass++;
            @(negedge clk);
        end
        mi_ready = 1; #1;
        n_tot++;
        if ({c1_ready, c0_ready} !== 2'b01)
            $display("FAIL stall_accept got %b want 01", {c1_ready, c0_ready});
        else n_pass++;
        @(negedge clk);
        c0_valid = 0; mi_wack = 1; mi_wlast = 1; #1;
        n_tot++;
        if ({c1_ready, c0_wack} !== 2'b01)
            $display("FAIL stall_data got r1=%b wa0=%b want 0 1",
                     c1_ready, c0_wack);
        else n_pass++;
        @(negedge clk);
        mi_wack = 0; mi_wlast = 0; #1;
        n_tot++;
        if (c1_ready !== 1'b0)
            $display("FAIL stall_idle got c1_ready=%b want 0", c1_ready);
        else n_pass++;
        @(negedge clk); #1;
        n_tot++;
        if ({c1_ready, mi_addr} !== {1'b1, 32'h400})
            $display("FAIL stall_c1 got r=%b a=%h want 1 400", c1_ready, mi_addr);
        else n_pass++;
        @(negedge clk);
        c1_valid = 0; mi_ready = 0; mi_wack = 1; mi_wlast = 1; #1;
        n_tot++;
        if (c1_wack !== 1'b1)
            $display("FAIL stall_c1_wack got %b want 1", c1_wack);
        else n_pass++;
        @(negedge clk);
        clr_ctl();
    endtask

    task automatic test_reset_mid();
        c0_addr = 32'h500; c0_len = 7'd63; c0_rw = 0; c0_valid = 1;
        @(negedge clk); mi_ready = 1; #1;
        n_tot++;
        if (c0_ready !== 1'b1)
            $display("FAIL rm_accept got %b want 1", c0_ready);
        else n_pass++;
        @(negedge clk);
        c0_valid = 0; mi_ready = 0;
        for (int i = 0; i < 20; i++) begin
            mi_wack = 1; mi_wlast = 0; c0_wdata = 16'(i);
            @(negedge clk);
        end
        rst = 1; #1;
        n_tot++;
        if (c0_wack !== 1'b1)
            $display("FAIL rm_before got c0_wack=%b want 1", c0_wack);
        else n_pass++;
        mi_wlast = 1; mi_rstb = 1; mi_rlast = 1;
        @(negedge clk); #1;
        n_tot++;
        if ({c0_wack, c0_wlast, c0_rstb, c0_rlast,
             c1_wack, c1_wlast, c1_rstb, c1_rlast, mi_valid} !== 9'h000)
            $display("FAIL rm_after got %b want 0",
                     {c0_wack, c0_wlast, c0_rstb, c0_rlast,
                      c1_wack, c1_wlast, c1_rstb, c1_rlast, mi_valid});
        else n_pass++;
        rst = 0; clr_ctl();
        c1_addr = 32'h600; c1_len = 0; c1_rw = 0; c1_valid = 1;
        @(negedge clk); mi_ready = 1; #1;
        n_tot++;
        if ({mi_valid, mi_addr, c1_ready} !== {1'b1, 32'h600, 1'b1})
            $display("FAIL rm_c1 got v=%b a=%h r=%b want 1 600 1",
                     mi_valid, mi_addr, c1_ready);
        else n_pass++;
        @(negedge clk);
        c1_valid = 0; mi_ready = 0; mi_wack = 1; mi_wlast = 1;
        @(negedge clk);
        clr_ctl();
    endtask

    task automatic test_drop();
        c0_addr = 32'h700; c0_len = 0; c0_rw = 0; c0_valid = 1;
        @(negedge clk); #1;
        n_tot++;
        if (mi_valid !== 1'b1)
            $display("FAIL drop_cmd got %b want 1", mi_valid);
        else n_pass++;
        c0_valid = 0; mi_ready = 1; #1;
        n_tot++;
        if ({mi_valid, c0_ready, c1_ready} !== 3'b000)
            $display("FAIL drop_nohs got %b want 000",
                     {mi_valid, c0_ready, c1_ready});
        else n_pass++;
        @(negedge clk);
        mi_ready = 0; c0_valid = 1;
        c1_addr = 32'h800; c1_valid = 1; #1;
        n_tot++;
        if (mi_valid !== 1'b0)
            $display("FAIL drop_idle got %b want 0", mi_valid);
        else n_pass++;
        @(negedge clk); mi_ready = 1; #1;
        n_tot++;
        if ({c1_ready, c0_ready, mi_addr} !== {2'b01, 32'h700})
            $display("FAIL drop_lastgnt got r=%b%b a=%h want 01 700",
                     c1_ready, c0_ready, mi_addr);
        else n_pass++;
        @(negedge clk);
        c0_valid = 0; c1_valid = 0; mi_ready = 0;
        mi_wack = 1; mi_wlast = 1;
        @(negedge clk);
        clr_ctl();
    endtask

    initial begin
        clk = 0; rst = 1;
        c0_addr = 0; c0_len = 0; c0_rw = 0; c0_valid = 0; c0_wdata = 0;
        c1_addr = 0; c1_len = 0; c1_rw = 0; c1_valid = 0; c1_wdata = 0;
        clr_ctl();
        test_reset();
        test_write_burst();
        test_round_robin();
        test_read();
        test_stall();
        test_reset_mid();
        test_drop();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
